// File: rtl/if_prefetch_unit_pkg.sv
// if_prefetch_unit_pkg: shared width, NOP encoding and prefetch entry type for the fetch stage
// Ports: none (package).
package if_prefetch_unit_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP = 32'h0000_0013;
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/if_prefetch_unit_if.sv
// if_prefetch_unit_if: pipelined instruction-memory request/response bus
// Ports: req/addr (fetch -> memory), gnt/rvalid/rdata (memory -> fetch).
// master = fetch unit side, slave = memory side.
interface if_prefetch_unit_if
    import if_prefetch_unit_pkg::*;
#(
    parameter int W = XLEN
);
    logic         req;
    logic [W-1:0] addr;
    logic         gnt;
    logic         rvalid;
    logic [W-1:0] rdata;
    modport master (output req, addr, input gnt, rvalid, rdata);
    modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/if_prefetch_unit_sync_fifo.sv
// if_prefetch_unit_sync_fifo: synchronous FIFO with flush, occupancy count and empty/full flags
// Ports: clk, rst, push_i, pop_i, flush_i, data_i -> data_o (head), count_o, empty_o, full_o.
module if_prefetch_unit_sync_fifo #(
    parameter  int W     = 8,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic          flush_i,
    input  logic [W-1:0]  data_i,
    output logic [W-1:0]  data_o,
    output logic [CW-1:0] count_o,
    output logic          empty_o,
    output logic          full_o
);
    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] count_q;

    always_comb begin
        data_o  = mem_q[rptr_q];
        count_o = count_q;
        empty_o = count_q == '0;
        full_o  = count_q == CW'(DEPTH);
    end

    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[wptr_q] <= data_i;
    end

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_i) wptr_q <= wptr_q + AW'(1);
            if (pop_i) rptr_q <= rptr_q + AW'(1);
            count_q <= count_q + CW'(push_i) - CW'(pop_i);
        end
    end
endmodule

// File: rtl/if_prefetch_unit.sv
// if_prefetch_unit: instruction fetch stage with pipelined imem requests, prefetch buffer and redirect flush
// Ports: clk, rst; imem (master: req/addr out, gnt/rvalid/rdata in);
//        redirect_valid_i/redirect_pc_i (branch/trap/mret), stall_i (downstream busy);
//        instr_valid_o/instr_o/instr_pc_o (head of prefetch buffer, NOP when empty).
module if_prefetch_unit
    import if_prefetch_unit_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    if_prefetch_unit_if.master  imem,
    input  logic                redirect_valid_i,
    input  logic [XLEN-1:0]     redirect_pc_i,
    input  logic                stall_i,
    output logic                instr_valid_o,
    output logic [XLEN-1:0]     instr_o,
    output logic [XLEN-1:0]     instr_pc_o
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]   outstanding_q, outstanding_d, discard_q, discard_d, count;
    logic [CW:0]     inflight;
    logic            issue, push, pop, empty, full;
    fetch_entry_t    push_entry, head;

    always_comb begin
        // credit covers both in-flight requests and buffered entries, so the FIFO can never overflow
        inflight      = {1'b0, outstanding_q} + {1'b0, count};
        imem.req      = !rst && !redirect_valid_i && inflight < (CW+1)'(DEPTH);
        imem.addr     = fetch_pc_q;
        issue         = imem.req && imem.gnt;
        push          = imem.rvalid && discard_q == '0 && !redirect_valid_i;
        pop           = !empty && !stall_i && !redirect_valid_i;
        // once discards are drained, every outstanding request is live and sequential,
        // so the oldest one sits outstanding words behind the fetch PC
        push_entry    = '{pc: fetch_pc_q - XLEN'({outstanding_q, 2'b00}), instr: imem.rdata};
        outstanding_d = outstanding_q + CW'(issue) - CW'(imem.rvalid);
        discard_d     = redirect_valid_i ? outstanding_q - CW'(imem.rvalid)
                      : (imem.rvalid && discard_q != '0) ? discard_q - CW'(1) : discard_q;
        fetch_pc_d    = redirect_valid_i ? {redirect_pc_i[XLEN-1:2], 2'b00}
                      : issue ? fetch_pc_q + XLEN'(4) : fetch_pc_q;
        instr_valid_o = !empty;
        instr_o       = empty ? NOP : head.instr;
        instr_pc_o    = empty ? fetch_pc_q : head.pc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    if_prefetch_unit_sync_fifo #(.W($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (redirect_valid_i),
        .data_i  (push_entry),
        .data_o  (head),
        .count_o (count),
        .empty_o (empty),
        .full_o  (full)
    );

    a_no_underflow: assert property (@(posedge clk) disable iff (rst) imem.rvalid |-> outstanding_q != '0);
    a_discard_le:   assert property (@(posedge clk) disable iff (rst) discard_q <= outstanding_q);
    a_no_overflow:  assert property (@(posedge clk) disable iff (rst) push |-> !full);
endmodule
